// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-predictor controller slice.
//   BP_ENTRIES / BP_IDX_W : predictor table depth and index width
//   bp_ctrl_state_e       : invalidate-sweep FSM states
//   WP_*                  : EX-stage misprediction codes from the predictor
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_ENTRIES = 32;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } bp_ctrl_state_e;

    localparam logic [1:0] WP_OK        = 2'b00;
    localparam logic [1:0] WP_NOT_TAKEN = 2'b01;
    localparam logic [1:0] WP_TAKEN     = 2'b10;

endpackage

// File: rtl/bp_sweep_fsm.sv
// -----------------------------------------------------------------------------
// bp_sweep_fsm
// Predictor-invalidate sweep sequencer: walks every table index once,
// asserting a write strobe per index, then pulses done for one cycle.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inv_req_i       invalidate request (level, only honoured in IDLE)
//   state_o         current FSM state (debug visibility)
//   sweep_we_o      write-invalid strobe for sweep_idx_o
//   sweep_idx_o     index being invalidated
//   inv_busy_o      sweep in progress
//   inv_done_o      one-cycle pulse after the last write
// -----------------------------------------------------------------------------
module bp_sweep_fsm
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = BP_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inv_req_i,
    output bp_ctrl_state_e   state_o,
    output logic             sweep_we_o,
    output logic [IDX_W-1:0] sweep_idx_o,
    output logic             inv_busy_o,
    output logic             inv_done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    // All outputs are registered alongside the state so they change together.
    // The index wraps to 0 on the last write, so it reads 0 outside a sweep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o     <= IDLE;
            sweep_we_o  <= 1'b0;
            sweep_idx_o <= '0;
            inv_busy_o  <= 1'b0;
            inv_done_o  <= 1'b0;
        end else begin
            case (state_o)
                IDLE: begin
                    inv_done_o <= 1'b0;
                    if (inv_req_i) begin
                        state_o     <= SWEEP;
                        sweep_idx_o <= '0;
                        sweep_we_o  <= 1'b1;
                        inv_busy_o  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Advances every cycle; pipeline stalls do not hold the sweep.
                    sweep_idx_o <= sweep_idx_o + IDX_W'(1);
                    if (sweep_idx_o == LAST_IDX) begin
                        state_o    <= DONE;
                        sweep_we_o <= 1'b0;
                        inv_busy_o <= 1'b0;
                        inv_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    // Requests seen here are absorbed; a still-high request
                    // restarts only once back in IDLE.
                    state_o    <= IDLE;
                    inv_done_o <= 1'b0;
                end
                default: begin
                    state_o     <= IDLE;
                    sweep_we_o  <= 1'b0;
                    sweep_idx_o <= '0;
                    inv_busy_o  <= 1'b0;
                    inv_done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// -----------------------------------------------------------------------------
// bp_ctrl
// Branch-predictor controller: turns the EX-stage misprediction code into a
// fetch redirect and IF/ID flush, gates predictor training, and runs the
// invalidate sweep (bp_sweep_fsm) that blocks lookups and updates meanwhile.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   ex_valid_i, stall_i         EX instruction valid / pipeline stall
//   wrong_pred_i                predictor code (WP_*; 2'b11 treated as OK)
//   pc_ex_i, alu_pc_i           EX PC and resolved target
//   inv_req_i                   invalidate request (level)
//   redirect_o, redirect_pc_o   fetch override and target
//   flush_ifid_o                squash IF/ID and ID/EX
//   bp_update_en_o              predictor training enable
//   bp_lookup_en_o              predictor hit gating at fetch
//   sweep_we_o, sweep_idx_o     invalidate write strobe and index
//   inv_busy_o, inv_done_o      sweep busy / one-cycle completion pulse
// Optional (macro BP_PERF_CNT_EN):
//   br_cnt_o                    saturating count of bp_update_en_o cycles
//   mispred_cnt_o               saturating count of mispredicts
//
// Handshake: an EX instruction is consumed in a cycle where ex_valid_i=1 and
// stall_i=0; only a consumed instruction may redirect or train the predictor.
// -----------------------------------------------------------------------------
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = BP_IDX_W,
    parameter int XLEN    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    input  logic             stall_i,
    input  logic [1:0]       wrong_pred_i,
    input  logic [XLEN-1:0]  pc_ex_i,
    input  logic [XLEN-1:0]  alu_pc_i,
    input  logic             inv_req_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_ifid_o,
    output logic             bp_update_en_o,
    output logic             bp_lookup_en_o,
    output logic             sweep_we_o,
    output logic [IDX_W-1:0] sweep_idx_o,
    output logic             inv_busy_o,
    output logic             inv_done_o
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]      br_cnt_o,
    output logic [31:0]      mispred_cnt_o
`endif
);

    bp_ctrl_state_e state;
    logic           consumed;
    logic           mis;
    logic           shadow_q;
    logic           idle;

    bp_sweep_fsm #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_sweep (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inv_req_i   (inv_req_i),
        .state_o     (state),
        .sweep_we_o  (sweep_we_o),
        .sweep_idx_o (sweep_idx_o),
        .inv_busy_o  (inv_busy_o),
        .inv_done_o  (inv_done_o)
    );

    // Combinational outputs are qualified with rst_ni so every output reads 0
    // as soon as reset is asserted, not just after the next edge.
    assign consumed = rst_ni & ex_valid_i & ~stall_i;
    assign idle     = (state == IDLE);

    // The cycle after a mispredict carries a wrong-path instruction: it may
    // neither redirect nor train.
    assign mis = consumed & ~shadow_q &
                 ((wrong_pred_i == WP_NOT_TAKEN) | (wrong_pred_i == WP_TAKEN));

    assign redirect_o     = mis;
    assign flush_ifid_o   = mis;
    assign bp_update_en_o = consumed & ~shadow_q & idle;
    assign bp_lookup_en_o = rst_ni & idle;

    always_comb begin
        redirect_pc_o = '0;
        if (rst_ni) begin
            case (wrong_pred_i)
                WP_TAKEN:     redirect_pc_o = alu_pc_i;
                WP_NOT_TAKEN: redirect_pc_o = pc_ex_i + XLEN'(4);
                default:      redirect_pc_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= 1'b0;
        end else begin
            shadow_q <= mis;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_o      <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (bp_update_en_o && (br_cnt_o != 32'hFFFF_FFFF)) begin
                br_cnt_o <= br_cnt_o + 32'd1;
            end
            if (mis && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_ctrl.sv
module tb_bp_ctrl;
    import bp_pkg::*;

    localparam int XLEN    = 32;
    localparam int ENTRIES = BP_ENTRIES;
    localparam int IDX_W   = BP_IDX_W;
    // {redirect, redirect_pc, flush, update_en, lookup_en, we, idx, busy, done}
    localparam int W = 1 + XLEN + 1 + 1 + 1 + 1 + IDX_W + 1 + 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             ex_valid_i = 1'b0;
    logic             stall_i = 1'b0;
    logic [1:0]       wrong_pred_i = 2'b00;
    logic [XLEN-1:0]  pc_ex_i = '0;
    logic [XLEN-1:0]  alu_pc_i = '0;
    logic             inv_req_i = 1'b0;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             flush_ifid_o;
    logic             bp_update_en_o;
    logic             bp_lookup_en_o;
    logic             sweep_we_o;
    logic [IDX_W-1:0] sweep_idx_o;
    logic             inv_busy_o;
    logic             inv_done_o;
`ifdef BP_PERF_CNT_EN
    logic [31:0]      br_cnt_o;
    logic [31:0]      mispred_cnt_o;
`endif

    bp_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ex_valid_i     (ex_valid_i),
        .stall_i        (stall_i),
        .wrong_pred_i   (wrong_pred_i),
        .pc_ex_i        (pc_ex_i),
        .alu_pc_i       (alu_pc_i),
        .inv_req_i      (inv_req_i),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .flush_ifid_o   (flush_ifid_o),
        .bp_update_en_o (bp_update_en_o),
        .bp_lookup_en_o (bp_lookup_en_o),
        .sweep_we_o     (sweep_we_o),
        .sweep_idx_o    (sweep_idx_o),
        .inv_busy_o     (inv_busy_o),
        .inv_done_o     (inv_done_o)
`ifdef BP_PERF_CNT_EN
        ,
        .br_cnt_o       (br_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: sweep_pos = -1 when idle, 0..ENTRIES-1 while writing
    // that index, ENTRIES for the completion cycle.
    bit          shadow_m = 1'b0;
    int          sweep_pos = -1;
    logic [31:0] br_m = '0;
    logic [31:0] mis_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic ex, input logic st, input logic [1:0] wp,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu, input logic inv);
        logic [W-1:0]    e;
        logic            m, idle, we, upd;
        logic [XLEN-1:0] rpc;
        logic [IDX_W-1:0] idx;
        @(posedge clk_i);
        #1;
        ex_valid_i = ex; stall_i = st; wrong_pred_i = wp;
        pc_ex_i = pc; alu_pc_i = alu; inv_req_i = inv;
        rst_ni = rst;
        if (!rst) begin
            shadow_m = 1'b0; sweep_pos = -1; br_m = '0; mis_m = '0;
            e = '0;
        end else begin
            m    = ex && !st && !shadow_m && (wp == 2'b01 || wp == 2'b10);
            idle = (sweep_pos < 0);
            we   = (sweep_pos >= 0) && (sweep_pos < ENTRIES);
            upd  = ex && !st && !shadow_m && idle;
            rpc  = (wp == 2'b10) ? alu : (wp == 2'b01) ? pc + 32'd4 : '0;
            idx  = we ? IDX_W'(sweep_pos) : '0;
            e = {m, rpc, m, upd, idle, we, idx, we, logic'(sweep_pos == ENTRIES)};
            shadow_m = m;
            if (idle)                     sweep_pos = inv ? 0 : -1;
            else if (sweep_pos == ENTRIES) sweep_pos = -1;
            else                          sweep_pos++;
            if (upd && br_m != 32'hFFFF_FFFF)  br_m++;
            if (m && mis_m != 32'hFFFF_FFFF)   mis_m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic rand_step(input logic inv);
        step(1'b1, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 4) == 0),
             2'($urandom_range(0, 3)), {$urandom, 2'b00} , $urandom, inv);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [W-1:0]     e;
        logic             e_red, e_fl, e_up, e_lk, e_we, e_busy, e_done;
        logic [XLEN-1:0]  e_pc;
        logic [IDX_W-1:0] e_idx;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {e_red, e_pc, e_fl, e_up, e_lk, e_we, e_idx, e_busy, e_done} = e;
            check("redirect",    64'(redirect_o),     64'(e_red));
            check("redirect_pc", 64'(redirect_pc_o),  64'(e_pc));
            check("flush_ifid",  64'(flush_ifid_o),   64'(e_fl));
            check("update_en",   64'(bp_update_en_o), 64'(e_up));
            check("lookup_en",   64'(bp_lookup_en_o), 64'(e_lk));
            check("sweep_we",    64'(sweep_we_o),     64'(e_we));
            check("sweep_idx",   64'(sweep_idx_o),    64'(e_idx));
            check("inv_busy",    64'(inv_busy_o),     64'(e_busy));
            check("inv_done",    64'(inv_done_o),     64'(e_done));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset held for a few cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h20, 1'b1);

        // directed: correct prediction, mispredict + shadow, wraparound, stall, illegal code
        step(1'b1, 1'b1, 1'b0, WP_OK,        32'h0000_0100, 32'h0000_0200, 1'b0);
        step(1'b1, 1'b1, 1'b0, WP_TAKEN,     32'h0000_0104, 32'h0000_0400, 1'b0);
        step(1'b1, 1'b1, 1'b0, WP_NOT_TAKEN, 32'h0000_0108, 32'h0000_0999, 1'b0);
        step(1'b1, 1'b1, 1'b0, WP_OK,        32'h0000_010C, 32'h0000_0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, WP_NOT_TAKEN, 32'hFFFF_FFFC, 32'h0000_1234, 1'b0);
        step(1'b1, 1'b1, 1'b0, WP_OK,        32'h0000_0000, 32'h0000_0000, 1'b0);
        step(1'b1, 1'b1, 1'b1, WP_NOT_TAKEN, 32'hFFFF_FFFC, 32'h0000_1234, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b11,        32'h0000_0200, 32'h0000_0300, 1'b0);
        step(1'b1, 1'b0, 1'b0, WP_TAKEN,     32'h0000_0200, 32'h0000_0300, 1'b0);

        // directed sweep with a second request mid-sweep that must be absorbed
        step(1'b1, 1'b1, 1'b0, WP_OK, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < ENTRIES + 3; i++) rand_step(logic'(i == 9));

        // reset in the middle of a sweep
        step(1'b1, 1'b1, 1'b0, WP_OK, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 64 && sweep_pos != 15; i++) rand_step(1'b0);
        check("sweep_reached_15", 64'(sweep_pos), 64'd15);
        step(1'b0, 1'b1, 1'b0, WP_TAKEN, 32'h0, 32'h44, 1'b0);
        #1;
        check("rst_we_immediate",   64'(sweep_we_o),  64'd0);
        check("rst_busy_immediate", 64'(inv_busy_o),  64'd0);
        check("rst_redir_immediate", 64'(redirect_o), 64'd0);
        step(1'b0, 1'b1, 1'b0, WP_OK, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 40; i++) rand_step(1'b0);

        // randomized traffic with occasional (sometimes held) invalidate requests
        for (int i = 0; i < 1500; i++) rand_step(logic'($urandom_range(0, 49) == 0));

        @(negedge clk_i);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef BP_PERF_CNT_EN
        check("br_cnt",      64'(br_cnt_o),      64'(br_m));
        check("mispred_cnt", 64'(mispred_cnt_o), 64'(mis_m));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
